bp_be_fp_int_wb_pipe: RTL and testbench
=======================================

Name: bp_be_fp_int_wb_pipe

Overview:
Downstream writeback stage for the FP-to-integer unit (FEQ/FLT/FLE, FCLASS, FCVT to integer, FMV to integer). It registers the unit's 64-bit integer result and exception flags through a fixed-latency stallable pipeline. It presents each result to the integer register-file writeback port with a valid/ready handshake. It also keeps the sticky fflags accrual register that feeds the FCSR.

Parameters:
dword_width_p, 64, width of integer result
reg_addr_width_p, 5, integer destination register index width
latency_p, 2, pipeline depth in cycles from accept to wb_v_o; legal 1..4

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous active-high reset
v_i  in  1  result from FP-int unit valid
ready_o  out  1  stage can accept this cycle
data_i  in  dword_width_p  integer result from FP-int unit
eflags_i  in  5  exception flags {nv,dz,of,uf,nx} from FP-int unit
rd_addr_i  in  reg_addr_width_p  destination integer register
flush_i  in  1  discard all in-flight entries
wb_v_o  out  1  writeback entry valid
wb_ready_i  in  1  register file accepts writeback
wb_data_o  out  dword_width_p  writeback data
wb_rd_addr_o  out  reg_addr_width_p  writeback destination
wb_eflags_o  out  5  flags of the entry at writeback
fflags_w_v_i  in  1  CSR write to fflags
fflags_w_i  in  5  CSR write data
fflags_o  out  5  sticky accrued flags
empty_o  out  1  no valid entry in any stage

Behaviour:
- Reset state: all stage valid bits are 0. wb_v_o=0, fflags_o=0, empty_o=1, ready_o=1. Data, address and flag stage registers reset to 0.
- Stage storage: latency_p stages, each holding {valid, data, rd_addr, eflags}. The last stage drives the wb_* outputs directly, with no combinational path from inputs to outputs.
- stall = wb_v_o & ~wb_ready_i.
- ready_o = ~stall. This is a whole-pipe stall with no bubble collapsing.
- Acceptance: an entry is accepted when v_i & ready_o & ~flush_i.
- Advance: when ~stall, every stage shifts by one. Stage 0 loads the accepted entry, or a bubble if nothing is accepted. When stall, all stages hold.
- Latency: with no stalls, an entry accepted in cycle t gives wb_v_o=1 in cycle t+latency_p. Throughput is 1 per cycle.
- Retire: an entry retires when wb_v_o & wb_ready_i.
- Flush: the next cycle has all valid bits cleared. A v_i in the flush cycle is dropped. A retire handshake in the same cycle as flush_i still completes and its flags accrue.
- fflags next-state:
  - if fflags_w_v_i: fflags_w_i (the CSR write overrides a same-cycle retire accrual)
  - else if retire: fflags_o | wb_eflags_o
  - else: hold
- fflags persists across flush.
- empty_o = ~|valid bits, registered-derived.
- Asynchronous reset mid-operation drops all entries and clears fflags immediately.

Test Plan:
- Latency: reset, then latency_p=2 and wb_ready_i=1. Accept data_i=0x1, rd=5, eflags=0 at cycle 0 → wb_v_o=1 at cycle 2 with data 0x1, rd 5. empty_o=1 again at cycle 3.
- Back-to-back: send 4 entries with data 0xA..0xD, one per cycle, wb_ready_i=1 → retire in order 0xA,0xB,0xC,0xD in consecutive cycles, ready_o stays 1 throughout.
- Stall: wb_ready_i=0 while 0xA is at output and 0xB is behind it → ready_o=0 and outputs hold 0xA. When wb_ready_i=1, 0xA retires, then 0xB next cycle, with no duplication or loss.
- Flush: two entries in flight, assert flush_i with v_i=1 → the next cycle wb_v_o=0 and empty_o=1. The flush-cycle input never appears.
- Accrual: retire entries with eflags 5'b10000, then 5'b00001 → fflags_o=5'b10001. A following flush keeps 5'b10001.
- CSR write collision: fflags_w_v_i=1 with fflags_w_i=0 in the same cycle as a retire with eflags 5'b00100 → fflags_o=0 the next cycle. Then assert reset_i mid-stream → all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/bp_be_fp_int_wb_pipe.sv
// Writeback stage for the FP-to-integer unit.
// A fixed-depth, whole-pipe-stall shift pipeline carries the 64-bit integer
// result, its destination register and its exception flags. The last stage
// drives the integer register-file writeback handshake. A sticky fflags
// register accrues the flags of every retired entry and takes CSR writes.
module bp_be_fp_int_wb_pipe #(
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned latency_p        = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [dword_width_p-1:0]    data_i,
  input  logic [4:0]                  eflags_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,

  input  logic                        flush_i,

  output logic                        wb_v_o,
  input  logic                        wb_ready_i,
  output logic [dword_width_p-1:0]    wb_data_o,
  output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
  output logic [4:0]                  wb_eflags_o,

  input  logic                        fflags_w_v_i,
  input  logic [4:0]                  fflags_w_i,
  output logic [4:0]                  fflags_o,

  output logic                        empty_o
);

  localparam int unsigned last_lp = latency_p - 1;

  // Per-stage storage; index 0 is the entry stage, last_lp feeds writeback.
  logic [latency_p-1:0]        valid_q, valid_d;
  logic [dword_width_p-1:0]    data_q   [latency_p];
  logic [dword_width_p-1:0]    data_d   [latency_p];
  logic [reg_addr_width_p-1:0] rd_q     [latency_p];
  logic [reg_addr_width_p-1:0] rd_d     [latency_p];
  logic [4:0]                  eflags_q [latency_p];
  logic [4:0]                  eflags_d [latency_p];
  logic [4:0]                  fflags_q, fflags_d;

  logic stall;
  logic accept;
  logic retire;

  // Handshake decode: the whole pipe freezes while the head entry waits.
  always_comb begin
    stall  = valid_q[last_lp] & ~wb_ready_i;
    accept = v_i & ~stall & ~flush_i;
    retire = valid_q[last_lp] & wb_ready_i;
  end

  // Stage shift: load/bubble into stage 0 and advance all stages unless stalled.
  // Flush only clears valid bits; payloads of dropped entries are don't-care.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    rd_d     = rd_q;
    eflags_d = eflags_q;
    if (!stall) begin
      valid_d[0]  = accept;
      data_d[0]   = accept ? data_i    : '0;
      rd_d[0]     = accept ? rd_addr_i : '0;
      eflags_d[0] = accept ? eflags_i  : '0;
      for (int unsigned i = 1; i < latency_p; i++) begin
        valid_d[i]  = valid_q[i-1];
        data_d[i]   = data_q[i-1];
        rd_d[i]     = rd_q[i-1];
        eflags_d[i] = eflags_q[i-1];
      end
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Sticky accrued flags: a CSR write wins over a same-cycle retire accrual.
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_w_v_i) begin
      fflags_d = fflags_w_i;
    end else if (retire) begin
      fflags_d = fflags_q | eflags_q[last_lp];
    end
  end

  // Pipeline and fflags registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      fflags_q <= '0;
      for (int unsigned i = 0; i < latency_p; i++) begin
        data_q[i]   <= '0;
        rd_q[i]     <= '0;
        eflags_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      eflags_q <= eflags_d;
      fflags_q <= fflags_d;
    end
  end

  // Outputs come straight from registers except ready_o, which follows wb_ready_i.
  always_comb begin
    ready_o      = ~stall;
    wb_v_o       = valid_q[last_lp];
    wb_data_o    = data_q[last_lp];
    wb_rd_addr_o = rd_q[last_lp];
    wb_eflags_o  = eflags_q[last_lp];
    fflags_o     = fflags_q;
    empty_o      = ~|valid_q;
  end

endmodule

// File: tb/tb_bp_be_fp_int_wb_pipe.sv
// Testbench for bp_be_fp_int_wb_pipe: directed scenario tasks plus a
// negedge scoreboard monitor checking retire order, payload and latency.
module tb_bp_be_fp_int_wb_pipe;

  localparam int LAT = 2;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [63:0] data_i;
  logic [4:0]  eflags_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        wb_v_o;
  logic        wb_ready_i;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic [4:0]  wb_eflags_o;
  logic        fflags_w_v_i;
  logic [4:0]  fflags_w_i;
  logic [4:0]  fflags_o;
  logic        empty_o;

  int total = 0;
  int bad   = 0;

  bp_be_fp_int_wb_pipe #(
    .dword_width_p(64),
    .reg_addr_width_p(5),
    .latency_p(LAT)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .eflags_i(eflags_i),
    .rd_addr_i(rd_addr_i),
    .flush_i(flush_i),
    .wb_v_o(wb_v_o),
    .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o),
    .wb_rd_addr_o(wb_rd_addr_o),
    .wb_eflags_o(wb_eflags_o),
    .fflags_w_v_i(fflags_w_v_i),
    .fflags_w_i(fflags_w_i),
    .fflags_o(fflags_o),
    .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected entries in acceptance order, with pipeline age.
  logic [63:0] sb_data[$];
  logic [4:0]  sb_rd[$];
  logic [4:0]  sb_ef[$];
  int          sb_age[$];
  logic [63:0] m_d;
  logic [4:0]  m_r;
  logic [4:0]  m_e;
  int          m_a;
  logic        m_stall;

  // Inputs and outputs are stable at the negedge; decide what the next posedge does.
  always @(negedge clk) begin
    if (reset_i) begin
      sb_data.delete(); sb_rd.delete(); sb_ef.delete(); sb_age.delete();
    end else begin
      m_stall = wb_v_o && !wb_ready_i;
      if (wb_v_o && wb_ready_i) begin
        total++;
        if (sb_data.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got data=%h rd=%0d, required no valid entry", wb_data_o, wb_rd_addr_o);
        end else begin
          m_d = sb_data.pop_front(); m_r = sb_rd.pop_front();
          m_e = sb_ef.pop_front();   m_a = sb_age.pop_front();
          if (wb_data_o !== m_d || wb_rd_addr_o !== m_r || wb_eflags_o !== m_e || m_a != LAT-1) begin
            bad++;
            $display("FAIL sb_retire: got data=%h rd=%0d ef=%b age=%0d, required data=%h rd=%0d ef=%b age=%0d",
                     wb_data_o, wb_rd_addr_o, wb_eflags_o, m_a, m_d, m_r, m_e, LAT-1);
          end
        end
      end
      if (flush_i) begin
        sb_data.delete(); sb_rd.delete(); sb_ef.delete(); sb_age.delete();
      end else begin
        if (!m_stall) begin
          for (int i = 0; i < sb_age.size(); i++) sb_age[i] = sb_age[i] + 1;
        end
        if (v_i && !m_stall) begin
          sb_data.push_back(data_i); sb_rd.push_back(rd_addr_i);
          sb_ef.push_back(eflags_i); sb_age.push_back(0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wb_v_o !== 1'b0) begin bad++; $display("FAIL rst_wb_v: got %b want 0", wb_v_o); end
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL rst_fflags: got %b want 00000", fflags_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    total++; if (wb_data_o !== 64'h0 || wb_rd_addr_o !== 5'd0) begin
      bad++; $display("FAIL rst_data: got %h/%0d want 0/0", wb_data_o, wb_rd_addr_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    wb_ready_i = 1'b1;
    data_i = 64'h1; rd_addr_i = 5'd5; eflags_i = 5'b0; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    total++; if (wb_v_o !== 1'b0 || empty_o !== 1'b0) begin
      bad++; $display("FAIL lat_c1: got wb_v=%b empty=%b want 0/0", wb_v_o, empty_o);
    end
    tick();
    total++; if (wb_v_o !== 1'b1 || wb_data_o !== 64'h1 || wb_rd_addr_o !== 5'd5) begin
      bad++; $display("FAIL lat_c2: got v=%b data=%h rd=%0d want 1/1/5", wb_v_o, wb_data_o, wb_rd_addr_o);
    end
    tick();
    total++; if (empty_o !== 1'b1 || wb_v_o !== 1'b0) begin
      bad++; $display("FAIL lat_c3: got empty=%b v=%b want 1/0", empty_o, wb_v_o);
    end
  endtask

  task automatic test_back_to_back;
    wb_ready_i = 1'b1; eflags_i = 5'b0;
    for (int i = 0; i < 4; i++) begin
      data_i = 64'hA + 64'(i); rd_addr_i = 5'(i + 1); v_i = 1'b1;
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, ready_o); end
      if (i >= 2) begin
        total++; if (wb_v_o !== 1'b1 || wb_data_o !== 64'hA + 64'(i - 2)) begin
          bad++; $display("FAIL b2b_out%0d: got v=%b data=%h want 1/%h", i, wb_v_o, wb_data_o, 64'hA + 64'(i - 2));
        end
      end
      tick();
    end
    v_i = 1'b0;
    total++; if (wb_data_o !== 64'hC) begin bad++; $display("FAIL b2b_c: got %h want c", wb_data_o); end
    tick();
    total++; if (wb_data_o !== 64'hD || ready_o !== 1'b1) begin
      bad++; $display("FAIL b2b_d: got data=%h ready=%b want d/1", wb_data_o, ready_o);
    end
    tick();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_stall;
    wb_ready_i = 1'b0; eflags_i = 5'b0;
    data_i = 64'hA; rd_addr_i = 5'd3; v_i = 1'b1;
    tick();
    data_i = 64'hB; rd_addr_i = 5'd4;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (ready_o !== 1'b0 || wb_v_o !== 1'b1 || wb_data_o !== 64'hA) begin
        bad++; $display("FAIL stall_hold%0d: got ready=%b v=%b data=%h want 0/1/a", i, ready_o, wb_v_o, wb_data_o);
      end
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL stall_release: got %b want 1", ready_o); end
    tick();
    total++; if (wb_v_o !== 1'b1 || wb_data_o !== 64'hB) begin
      bad++; $display("FAIL stall_b: got v=%b data=%h want 1/b", wb_v_o, wb_data_o);
    end
    tick();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL stall_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_flush;
    wb_ready_i = 1'b1; eflags_i = 5'b0;
    data_i = 64'h11; rd_addr_i = 5'd7; v_i = 1'b1;
    tick();
    data_i = 64'h22; rd_addr_i = 5'd8;
    tick();
    flush_i = 1'b1; data_i = 64'hEE; rd_addr_i = 5'd9;
    total++; if (wb_v_o !== 1'b1) begin bad++; $display("FAIL flush_pre: got v=%b want 1", wb_v_o); end
    tick();
    flush_i = 1'b0; v_i = 1'b0;
    total++; if (wb_v_o !== 1'b0 || empty_o !== 1'b1) begin
      bad++; $display("FAIL flush_clear: got v=%b empty=%b want 0/1", wb_v_o, empty_o);
    end
    repeat (4) tick();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL flush_stay: got %b want 1", empty_o); end
  endtask

  task automatic test_accrual;
    fflags_w_v_i = 1'b1; fflags_w_i = 5'b0;
    tick();
    fflags_w_v_i = 1'b0;
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL acc_clear: got %b want 00000", fflags_o); end
    wb_ready_i = 1'b1;
    data_i = 64'h30; rd_addr_i = 5'd1; eflags_i = 5'b10000; v_i = 1'b1;
    tick();
    data_i = 64'h31; eflags_i = 5'b00001;
    tick();
    v_i = 1'b0;
    tick();
    tick();
    total++; if (fflags_o !== 5'b10001) begin bad++; $display("FAIL acc_or: got %b want 10001", fflags_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    total++; if (fflags_o !== 5'b10001) begin bad++; $display("FAIL acc_flush: got %b want 10001", fflags_o); end
  endtask

  task automatic test_csr_collision;
    wb_ready_i = 1'b1;
    data_i = 64'h40; rd_addr_i = 5'd2; eflags_i = 5'b00100; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    total++; if (wb_v_o !== 1'b1 || fflags_o !== 5'b10001) begin
      bad++; $display("FAIL csr_pre: got v=%b fflags=%b want 1/10001", wb_v_o, fflags_o);
    end
    fflags_w_v_i = 1'b1; fflags_w_i = 5'b0;
    tick();
    fflags_w_v_i = 1'b0;
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL csr_override: got %b want 00000", fflags_o); end
  endtask

  task automatic test_async_reset;
    wb_ready_i = 1'b1; eflags_i = 5'b11111; v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 64'h50 + 64'(i); rd_addr_i = 5'(10 + i);
      tick();
    end
    total++; if (fflags_o !== 5'b11111 || wb_v_o !== 1'b1) begin
      bad++; $display("FAIL arst_pre: got fflags=%b v=%b want 11111/1", fflags_o, wb_v_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    total++; if (wb_v_o !== 1'b0 || fflags_o !== 5'b0 || empty_o !== 1'b1 || ready_o !== 1'b1 || wb_data_o !== 64'h0) begin
      bad++; $display("FAIL arst_now: got v=%b ff=%b empty=%b ready=%b data=%h want 0/00000/1/1/0",
                      wb_v_o, fflags_o, empty_o, ready_o, wb_data_o);
    end
    v_i = 1'b0;
    #3;
    reset_i = 1'b0;
    tick();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL arst_after: got %b want 1", empty_o); end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; eflags_i = '0; rd_addr_i = '0;
    flush_i = 1'b0; wb_ready_i = 1'b1; fflags_w_v_i = 1'b0; fflags_w_i = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_flush();
    test_accrual();
    test_csr_collision();
    test_async_reset();
    repeat (3) tick();
    total++;
    if (sb_data.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending entries want 0", sb_data.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
